sar_adc_seq: RTL and testbench

- Digital-side initiator for the SAR conversion handshake (start / done / data).
- Scans a masked set of analog channels:
  - drives the analog mux select;
  - waits a settle time, then pulses start;
  - captures the sample on done.
- Presents each result on a one-entry valid/ready output register.
- Sits between the SAR core and the register/bus block of the ADC subsystem.

---
 rtl/sar_adc_seq.sv | 177 +++++++++++++++++
 tb/tb_sar_adc_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_seq.sv
// SAR ADC scan sequencer: walks the enabled channels, runs the start/done
// handshake per channel and hands results out through a 1-entry register.
module sar_adc_seq #(
    parameter int SIZE    = 8,
    parameter int NCH     = 4,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 64,
    localparam int CHW    = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_en,
    input  logic            cfg_cont,
    input  logic [NCH-1:0]  cfg_mask,
    input  logic            trig,
    input  logic            ovr_clr,
    output logic [CHW-1:0]  ch_sel,
    output logic            adc_start,
    input  logic            adc_done,
    input  logic [SIZE-1:0] adc_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [CHW-1:0]  res_ch,
    output logic [SIZE-1:0] res_data,
    output logic            busy,
    output logic            overrun,
    output logic            timeout
);

    localparam int CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CNTW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_SETTLE, S_START, S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CHW-1:0]  ch_sel_q, ch_sel_d;
    logic [CHW-1:0]  res_ch_q, res_ch_d;
    logic [SIZE-1:0] res_data_q, res_data_d;
    logic            adc_start_q, adc_start_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic            timeout_q, timeout_d;

    logic [CHW-1:0]  lo_ch, nx_ch;
    logic            lo_any, nx_any;
    logic            cap, adv;

    // Lowest enabled channel, and lowest enabled channel above the pointer.
    always_comb begin
        lo_ch  = '0;
        lo_any = 1'b0;
        nx_ch  = '0;
        nx_any = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cfg_mask[i]) begin
                lo_ch  = CHW'(i);
                lo_any = 1'b1;
            end
            if (cfg_mask[i] && (i > int'(ch_sel_q))) begin
                nx_ch  = CHW'(i);
                nx_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_sel_d   = ch_sel_q;
        res_valid_d = res_valid_q;
        res_ch_d   = res_ch_q;
        res_data_d = res_data_q;
        overrun_d  = overrun_q & ~ovr_clr;
        timeout_d  = timeout_q & ~ovr_clr;
        cap        = 1'b0;
        adv        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_en && lo_any && (cfg_cont || trig)) begin
                    state_d  = S_SEL;
                    ch_sel_d = lo_ch;
                end
            end
            S_SEL: begin
                cnt_d   = CNTW'(SETTLE - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_START;
                else             cnt_d   = cnt_q - CNTW'(1);
            end
            S_START: begin
                cnt_d   = CNTW'(TIMEOUT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (adc_done) begin
                    cap = 1'b1;
                    adv = 1'b1;
                end else if (cnt_q == '0) begin
                    timeout_d = 1'b1;
                    adv       = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (nx_any && cfg_en) begin
                state_d  = S_SEL;
                ch_sel_d = nx_ch;
            end else if (cfg_cont && cfg_en && lo_any) begin
                state_d  = S_SEL;
                ch_sel_d = lo_ch;
            end else begin
                state_d = S_IDLE;
            end
        end

        // A capture into a full, unaccepted register is dropped.
        if (cap && (!res_valid_q || res_ready)) begin
            res_valid_d = 1'b1;
            res_data_d  = adc_data;
            res_ch_d    = ch_sel_q;
        end else if (cap) begin
            overrun_d = 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        adc_start_d = (state_d == S_START);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ch_sel_q    <= '0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            adc_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_sel_q    <= ch_sel_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            adc_start_q <= adc_start_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ch_sel    = ch_sel_q;
    assign adc_start = adc_start_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sar_adc_seq.sv
// Bench for sar_adc_seq: SAR core model, consumer model, event monitor,
// vector table, directed corner cases and randomized single scans.
module tb_sar_adc_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_en = 1'b0;
    logic       cfg_cont = 1'b0;
    logic [3:0] cfg_mask = '0;
    logic       trig = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       adc_done = 1'b0;
    logic [7:0] adc_data = '0;
    logic       res_ready = 1'b0;
    logic [1:0] ch_sel, res_ch;
    logic [7:0] res_data;
    logic       adc_start, res_valid, busy, overrun, timeout;

    always #5 clk = ~clk;

    sar_adc_seq #(.SIZE(8), .NCH(4), .SETTLE(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_cont(cfg_cont),
        .cfg_mask(cfg_mask), .trig(trig), .ovr_clr(ovr_clr),
        .ch_sel(ch_sel), .adc_start(adc_start), .adc_done(adc_done),
        .adc_data(adc_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_data(res_data), .busy(busy),
        .overrun(overrun), .timeout(timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       sar_on = 1'b1;
    logic       lat_rand = 1'b0;
    logic       clr_req = 1'b0;
    logic       clr_on_done = 1'b0;
    int         sar_lat = 3;
    int         rdy_mode = 1;
    int         pend = 0;
    int         stall = 0;
    logic [7:0] sar_val [4];

    int         start_cyc[$], done_cyc[$], rise_cyc[$], rv_cyc[$], tmo_cyc[$];
    logic [1:0] start_ch[$], got_ch[$];
    logic [7:0] got_data[$];
    int         exp_ch[$];

    typedef struct {
        logic [3:0]  mask;
        logic        en;
        logic        trig;
        int          n;
        logic [15:0] chs;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // SAR core: done + data `lat` cycles after start, data follows the mux.
    initial forever begin
        @(posedge clk);
        #2;
        adc_done = 1'b0;
        adc_data = 8'($urandom);
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                adc_done = 1'b1;
                adc_data = sar_val[ch_sel];
            end
        end
        if (adc_start && sar_on)
            pend = lat_rand ? int'($urandom_range(1, 12)) : sar_lat;
        ovr_clr = clr_req | (clr_on_done & adc_done);
    end

    // Consumer: never ready, always ready, or ready after 0..3 stall cycles.
    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0: res_ready = 1'b0;
            1: res_ready = 1'b1;
            default: begin
                if (res_valid && !res_ready) begin
                    if (stall == 0) res_ready = 1'b1;
                    else            stall--;
                end else begin
                    res_ready = 1'b0;
                    stall = int'($urandom_range(0, 3));
                end
            end
        endcase
    end

    logic       busy_p = 1'b0, rv_p = 1'b0, tmo_p = 1'b0;
    logic       start_p = 1'b0, hold_p = 1'b0;
    logic [7:0] hold_d = '0;
    logic [1:0] hold_c = '0;

    always @(negedge clk) begin
        if (adc_start) begin
            start_cyc.push_back(cyc);
            start_ch.push_back(ch_sel);
            check("start_one_cycle", start_p, 0);
        end
        if (adc_done) done_cyc.push_back(cyc);
        if (busy && !busy_p) rise_cyc.push_back(cyc);
        if (res_valid && !rv_p) rv_cyc.push_back(cyc);
        if (timeout && !tmo_p) tmo_cyc.push_back(cyc);
        if (res_valid && res_ready) begin
            got_ch.push_back(res_ch);
            got_data.push_back(res_data);
        end
        if (res_valid && hold_p) begin
            check("stall_data", res_data, hold_d);
            check("stall_ch", res_ch, hold_c);
        end
        hold_p  = res_valid && !res_ready;
        hold_d  = res_data;
        hold_c  = res_ch;
        busy_p  = busy;
        rv_p    = res_valid;
        tmo_p   = timeout;
        start_p = adc_start;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_q();
        start_cyc.delete(); done_cyc.delete(); rise_cyc.delete();
        rv_cyc.delete(); tmo_cyc.delete(); start_ch.delete();
        got_ch.delete(); got_data.delete();
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int n = 0; n < max && busy; n++) step();
        check("wait_idle", busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clr_q();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ch_sel"}, ch_sel, 0);
        check({tag, "_start"}, adc_start, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_ch"}, res_ch, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        tbl[0] = '{4'b0101, 1'b1, 1'b1, 2, 16'h0020};
        tbl[1] = '{4'b0000, 1'b1, 1'b1, 0, 16'h0000};
        tbl[2] = '{4'b1111, 1'b0, 1'b1, 0, 16'h0000};
        tbl[3] = '{4'b1111, 1'b1, 1'b0, 0, 16'h0000};
        tbl[4] = '{4'b1000, 1'b1, 1'b1, 1, 16'h0003};
        tbl[5] = '{4'b1110, 1'b1, 1'b1, 3, 16'h0321};
        tbl[6] = '{4'b1111, 1'b1, 1'b1, 4, 16'h3210};
        tbl[7] = '{4'b1001, 1'b1, 1'b1, 2, 16'h0030};
        sar_val[0] = 8'hA5; sar_val[1] = 8'h77;
        sar_val[2] = 8'h3C; sar_val[3] = 8'hC3;

        repeat (3) step();
        check_zero("reset");
        reset = 1'b0;
        clr_q();

        // Single scan, mask 0101
        cfg_mask = 4'b0101; cfg_en = 1'b1; cfg_cont = 1'b0;
        pulse_trig();
        wait_idle(400);
        repeat (3) step();
        check("t1_nres", got_ch.size(), 2);
        if (got_ch.size() == 2) begin
            check("t1_ch0", got_ch[0], 0);
            check("t1_d0", got_data[0], 8'hA5);
            check("t1_ch1", got_ch[1], 2);
            check("t1_d1", got_data[1], 8'h3C);
        end
        check("t1_nstart", start_ch.size(), 2);
        check("t1_ndone", done_cyc.size(), 2);
        check("t1_nrv", rv_cyc.size(), 2);
        check("t1_nrise", rise_cyc.size(), 1);
        if (start_ch.size() == 2 && done_cyc.size() == 2 &&
            rv_cyc.size() == 2 && rise_cyc.size() == 1) begin
            check("t1_sel0", start_ch[0], 0);
            check("t1_sel1", start_ch[1], 2);
            check("t1_sel_to_start", start_cyc[0] - rise_cyc[0], 5);
            check("t1_done_to_start", start_cyc[1] - done_cyc[0], 6);
            check("t1_rv_lat0", rv_cyc[0] - done_cyc[0], 1);
            check("t1_rv_lat1", rv_cyc[1] - done_cyc[1], 1);
        end
        check("t1_busy", busy, 0);

        for (int r = 0; r < 8; r++) begin
            clr_q();
            cfg_mask = tbl[r].mask;
            cfg_en   = tbl[r].en;
            trig     = tbl[r].trig;
            step();
            trig = 1'b0;
            check($sformatf("row%0d_busy", r), busy, tbl[r].n > 0);
            wait_idle(400);
            repeat (3) step();
            check($sformatf("row%0d_nres", r), got_ch.size(), tbl[r].n);
            for (int i = 0; i < tbl[r].n && i < got_ch.size(); i++) begin
                logic [3:0] e;
                e = tbl[r].chs[4*i +: 4];
                check($sformatf("row%0d_ch%0d", r, i), got_ch[i], e);
                check($sformatf("row%0d_d%0d", r, i), got_data[i], sar_val[e[1:0]]);
            end
        end

        // Continuous on ch3, drop enable in the third WAIT
        do_reset();
        cfg_mask = 4'b1000; cfg_cont = 1'b1; cfg_en = 1'b1;
        for (int n = 0; n < 300 && start_cyc.size() < 3; n++) step();
        check("c_third_start", start_cyc.size(), 3);
        cfg_en = 1'b0; cfg_cont = 1'b0;
        wait_idle(200);
        repeat (3) step();
        check("c_nres", got_ch.size(), 3);
        for (int i = 0; i < got_ch.size(); i++) begin
            check($sformatf("c_ch%0d", i), got_ch[i], 3);
            check($sformatf("c_d%0d", i), got_data[i], 8'hC3);
        end
        check("c_no_idle_gap", rise_cyc.size(), 1);
        check("c_nstart", start_cyc.size(), 3);
        cfg_en = 1'b1;

        // Backpressure and overrun
        do_reset();
        rdy_mode = 0;
        sar_val[0] = 8'h11; sar_val[1] = 8'h22;
        cfg_mask = 4'b0011;
        pulse_trig();
        wait_idle(400);
        repeat (3) step();
        check("bp_valid", res_valid, 1);
        check("bp_data", res_data, 8'h11);
        check("bp_ch", res_ch, 0);
        check("bp_overrun", overrun, 1);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("bp_clr", overrun, 0);
        clr_on_done = 1'b1;
        cfg_mask = 4'b0010;
        pulse_trig();
        wait_idle(400);
        repeat (3) step();
        clr_on_done = 1'b0;
        check("bp_drop_beats_clr", overrun, 1);
        check("bp_data_held", res_data, 8'h11);
        rdy_mode = 1;
        repeat (3) step();
        check("bp_drained", res_valid, 0);
        sar_val[0] = 8'hA5; sar_val[1] = 8'h77;

        // Timeout: SAR never answers
        do_reset();
        sar_on = 1'b0;
        cfg_mask = 4'b0011;
        pulse_trig();
        wait_idle(400);
        repeat (2) step();
        check("to_nstart", start_cyc.size(), 2);
        check("to_nrise", tmo_cyc.size(), 1);
        if (start_cyc.size() == 2 && tmo_cyc.size() == 1) begin
            check("to_next_ch", start_ch[1], 1);
            check("to_latency", tmo_cyc[0] - start_cyc[0], 65);
        end
        check("to_no_valid", rv_cyc.size(), 0);
        check("to_flag", timeout, 1);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("to_clr", timeout, 0);
        sar_on = 1'b1;

        // Trig while busy is not remembered
        do_reset();
        rdy_mode = 0;
        sar_lat = 20;
        cfg_mask = 4'b0001;
        pulse_trig();
        repeat (10) step();
        check("tb_busy", busy, 1);
        pulse_trig();
        wait_idle(400);
        repeat (10) step();
        check("tb_nstart", start_cyc.size(), 1);
        check("tb_idle", busy, 0);
        check("tb_valid", res_valid, 1);
        check("tb_data", res_data, 8'hA5);

        // Reset in the middle of WAIT, late done ignored
        clr_q();
        sar_lat = 10;
        cfg_mask = 4'b0100;
        pulse_trig();
        for (int n = 0; n < 50 && start_cyc.size() < 1; n++) step();
        check("rw_started", start_cyc.size(), 1);
        repeat (2) step();
        reset = 1'b1;
        step();
        check_zero("rw");
        reset = 1'b0;
        repeat (15) step();
        check("rw_late_valid", res_valid, 0);
        check("rw_late_busy", busy, 0);
        check("rw_nstart", start_cyc.size(), 1);
        sar_lat = 3;
        rdy_mode = 1;

        // Random single scans with a stalling consumer
        for (int it = 0; it < 30; it++) begin
            logic [3:0] m;
            m = 4'($urandom_range(1, 15));
            for (int c = 0; c < 4; c++) sar_val[c] = 8'($urandom);
            lat_rand = 1'b1;
            rdy_mode = 2;
            clr_q();
            cfg_mask = m; cfg_en = 1'b1; cfg_cont = 1'b0;
            pulse_trig();
            wait_idle(800);
            repeat (6) step();
            exp_ch.delete();
            for (int c = 0; c < 4; c++) if (m[c]) exp_ch.push_back(c);
            check($sformatf("rnd%0d_nres", it), got_ch.size(), exp_ch.size());
            check($sformatf("rnd%0d_nstart", it), start_cyc.size(), exp_ch.size());
            for (int i = 0; i < exp_ch.size() && i < got_ch.size(); i++) begin
                check($sformatf("rnd%0d_ch%0d", it, i), got_ch[i], exp_ch[i]);
                check($sformatf("rnd%0d_d%0d", it, i), got_data[i], sar_val[exp_ch[i]]);
            end
            check($sformatf("rnd%0d_overrun", it), overrun, 0);
            check($sformatf("rnd%0d_timeout", it), timeout, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
